// File: rtl/rv_pkg.sv
// Shared RISC-V core constants: default datapath width, register count and
// the index of the hardwired zero register.
package rv_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;
   localparam int REG_ZERO = 0;

endpackage : rv_pkg

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue of a producer
// and cleared when either writeback port retires a value into that register.
module rf_scoreboard
   import rv_pkg::*;
#(
   parameter int NREG = NREG_DEF,
   parameter int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we0,
   input  logic [AW-1:0]   wa0,
   input  logic            we1,
   input  logic [AW-1:0]   wa1,
   input  logic            iss_v,
   input  logic [AW-1:0]   iss_rd,
   output logic [NREG-1:0] pend_o
);

   logic [NREG-1:0] pend_q;
   logic [NREG-1:0] pend_d;

   // A same-cycle issue wins over a clear: the issued instruction is a newer
   // producer than whatever is retiring now.
   always_comb begin
      pend_d = pend_q;
      for (int r = 0; r < NREG; r++) begin
         if (iss_v && (iss_rd == AW'(r)) && (r != REG_ZERO)) begin
            pend_d[r] = 1'b1;
         end else if ((we0 && (wa0 == AW'(r))) || (we1 && (wa1 == AW'(r)))) begin
            pend_d[r] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign pend_o = pend_q;

endmodule : rf_scoreboard

// File: rtl/regfile_mp.sv
// Multi-port RISC-V register file: NRP combinational read ports, ALU and load
// writeback ports, optional write-to-read bypass and a pending-write scoreboard.
module regfile_mp
   import rv_pkg::*;
#(
   parameter  int XLEN   = XLEN_DEF,
   parameter  int NREG   = NREG_DEF,
   parameter  int NRP    = 2,
   parameter  int BYPASS = 1,
   localparam int AW     = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRP*AW-1:0]   ra,
   output logic [NRP*XLEN-1:0] rd,
   output logic [NRP-1:0]      rd_pend,
   input  logic                we0,
   input  logic [AW-1:0]       wa0,
   input  logic [XLEN-1:0]     wd0,
   input  logic                we1,
   input  logic [AW-1:0]       wa1,
   input  logic [XLEN-1:0]     wd1,
   input  logic                iss_v,
   input  logic [AW-1:0]       iss_rd,
   output logic                any_pend
);

   if ((NRP < 1) || (NRP > 4)) begin : gen_bad_nrp
      $error("regfile_mp: NRP must be in 1..4");
   end
   if ((NREG < 2) || ((1 << AW) != NREG)) begin : gen_bad_nreg
      $error("regfile_mp: NREG must be a power of two >= 2");
   end
   if ((BYPASS != 0) && (BYPASS != 1)) begin : gen_bad_bypass
      $error("regfile_mp: BYPASS must be 0 or 1");
   end
   if (XLEN < 1) begin : gen_bad_xlen
      $error("regfile_mp: XLEN must be positive");
   end

   logic [XLEN-1:0] regs_q [NREG];
   logic [NREG-1:0] pend;

   // Port 1 is written last so a same-address collision leaves the load data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            regs_q[r] <= '0;
         end
      end else begin
         if (we0 && (wa0 != AW'(REG_ZERO))) begin
            regs_q[wa0] <= wd0;
         end
         if (we1 && (wa1 != AW'(REG_ZERO))) begin
            regs_q[wa1] <= wd1;
         end
      end
   end

   rf_scoreboard #(
      .NREG (NREG),
      .AW   (AW)
   ) u_scoreboard (
      .clk    (clk),
      .rst    (rst),
      .we0    (we0),
      .wa0    (wa0),
      .we1    (we1),
      .wa1    (wa1),
      .iss_v  (iss_v),
      .iss_rd (iss_rd),
      .pend_o (pend)
   );

   for (genvar i = 0; i < NRP; i++) begin : gen_read
      logic [AW-1:0]   addr;
      logic            notZero;
      logic            hit0;
      logic            hit1;
      logic [XLEN-1:0] data;

      assign addr    = ra[i*AW +: AW];
      assign notZero = (addr != AW'(REG_ZERO));
      assign hit0    = (BYPASS != 0) && we0 && (wa0 == addr) && notZero;
      assign hit1    = (BYPASS != 0) && we1 && (wa1 == addr) && notZero;

      always_comb begin
         data = notZero ? regs_q[addr] : '0;
         if (hit1) begin
            data = wd1;
         end else if (hit0) begin
            data = wd0;
         end
      end

      assign rd[i*XLEN +: XLEN] = data;
      assign rd_pend[i]         = pend[addr] && !(hit0 || hit1);
   end

   assign any_pend = |pend;

endmodule : regfile_mp

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write, two-read RISC-V register file.
- N read ports, two write ports (port 0 = ALU writeback, port 1 = load writeback), optional write-to-read bypass, and a pending-write scoreboard for hazard detection.
- Sits between decode (reads, issue) and the writeback stage of the pipelined core.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; power of two, ≥2.
- AW, $clog2(NREG), address width; derived, not overridden.
- NRP, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ra  in  NRP*AW  read addresses, port i at [i*AW +: AW].
- rd  out  NRP*XLEN  read data, port i at [i*XLEN +: XLEN].
- rd_pend  out  NRP  port i's register has an outstanding write.
- we0  in  1  write enable, port 0.
- wa0  in  AW  write address, port 0.
- wd0  in  XLEN  write data, port 0.
- we1  in  1  write enable, port 1.
- wa1  in  AW  write address, port 1.
- wd1  in  XLEN  write data, port 1.
- iss_v  in  1  instruction issued with a destination register.
- iss_rd  in  AW  destination of the issued instruction.
- any_pend  out  1  OR of all pending bits.

Behaviour:
- Reset (asynchronous): all registers = 0, all pending bits = 0. rd, rd_pend and any_pend then read 0.
- Register 0 is hardwired:
  - Always reads 0.
  - Writes to it are dropped.
  - Its pending bit is never set.
- Storage write: on the rising clk edge, for each port with weX=1 and waX≠0, reg[waX] <= wdX.
- Write collision: we0 and we1 both set with wa0==wa1 → port 1 wins (load data is architecturally later).
- Read path is combinational, with zero cycles of latency.
  - BYPASS=0: rd_i = reg[ra_i].
  - BYPASS=1: rd_i = wd1 if we1 && wa1==ra_i && ra_i≠0; else wd0 if we0 && wa0==ra_i && ra_i≠0; else reg[ra_i].
- Pending bit pend[r] updates on the clock edge:
  - Cleared if any write port has weX && waX==r.
  - Set if iss_v && iss_rd==r && r≠0.
  - Set takes priority over clear in the same cycle: a newer producer was issued.
  - Otherwise holds.
- rd_pend_i:
  - BYPASS=1: pend[ra_i] && not (write to ra_i this cycle), since the bypass satisfies the hazard.
  - BYPASS=0: pend[ra_i] directly.
- any_pend = |pend, registered view (current pend state, no bypass masking).
- A write to a register whose pend=0 is legal: data is stored and pend stays 0.
- Reset mid-operation wipes all data and pending state immediately, independent of clk. Writes and issues in that cycle are lost.
- Out-of-range parameter values: elaboration-time error via generate-time check.

Decomposition:
- Shared package (rv_pkg) holds XLEN default, NREG default and the REG_ZERO constant.
- Sub-module rf_scoreboard (NREG, AW) holds the pend vector and its set/clear logic.
- Storage, write arbitration and the bypass mux live in regfile_mp.

Test Plan:
- Reset and zero register:
  - Stimulus: rst=1 then release; write we0=1, wa0=0, wd0=32'hDEADBEEF; read ra0=0.
  - Required: rd0=0 on every cycle, rd_pend0=0.
- Basic write/read:
  - Stimulus: we0=1, wa0=2, wd0=32'h12345678 for one cycle; next cycle ra0=2, ra1=1.
  - Required: rd0=32'h12345678, rd1=0.
- Bypass:
  - Stimulus: BYPASS=1; we0=1, wa0=5, wd0=32'hA5A5A5A5 with ra0=5 in the same cycle.
  - Required: rd0=32'hA5A5A5A5 that cycle.
  - Repeat with BYPASS=0: rd0=old value (0) that cycle, 32'hA5A5A5A5 the next.
- Write collision:
  - Stimulus: we0=1, wa0=7, wd0=32'h1111; we1=1, wa1=7, wd1=32'h2222.
  - Required: next cycle reg7 reads 32'h2222. With BYPASS=1, rd for ra=7 shows 32'h2222 in the collision cycle.
- Scoreboard:
  - Stimulus: iss_v=1, iss_rd=3.
  - Required: next cycle rd_pend for ra=3 is 1 and any_pend=1. After we1=1, wa1=3, pend clears: any_pend=0 the following cycle.
  - Same-cycle case: iss_rd=3 together with we0, wa0=3 → pend stays 1.
- Asynchronous reset mid-operation:
  - Stimulus: load reg4=32'hCAFEF00D, issue rd=4, then assert rst between clock edges.
  - Required: rd for ra=4 reads 0 immediately and any_pend=0 without waiting for a clk edge.
